fdd_timer_sched: RTL and testbench

Shared microsecond timer scheduler for the FDD controller. It derives a single tick enable (1 MHz by default) from the system clock and services a bank of programmable down-counters. Typical counters are motor-off timeout, step rate, head settle and index period. One shared decrementer is time-multiplexed across all counters by a sweep FSM. Consumers see only per-timer start/cancel/busy/expire handshakes.

---
 rtl/fdd_pkg.sv | 13 +
 rtl/fdd_tick_gen.sv | 31 +++
 rtl/fdd_timer_sched.sv | 146 ++++++++++++++
 tb/tb_fdd_timer_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fdd_pkg.sv
// rtl/fdd_pkg.sv - shared types and constant helpers for the FDD timer scheduler
package fdd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } tsched_state_t;

    function automatic int fdd_div(input int clk_freq, input int tick_freq);
        return clk_freq / tick_freq;
    endfunction

endpackage

// File: rtl/fdd_tick_gen.sv
// rtl/fdd_tick_gen.sv - resettable prescaler producing a one-cycle tick every DIV clocks
module fdd_tick_gen
    import fdd_pkg::*;
#(
    parameter int CLK_FREQ  = 21477270,
    parameter int TICK_FREQ = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    output logic en
);

    localparam int DIV = fdd_div(CLK_FREQ, TICK_FREQ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign en = (cnt == '0);

endmodule

// File: rtl/fdd_timer_sched.sv
// rtl/fdd_timer_sched.sv - bank of tick-based down-counters serviced by one shared decrementer
// Optional auto-reload of periodic timers: define FDD_TSCHED_AUTORELOAD_EN.
module fdd_timer_sched
    import fdd_pkg::*;
#(
    parameter int CLK_FREQ   = 21477270,
    parameter int TICK_FREQ  = 1000000,
    parameter int NUM_TIMERS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_TIMERS-1:0]       start,
    input  logic [NUM_TIMERS*CNT_W-1:0] load_val,
    input  logic [NUM_TIMERS-1:0]       cancel,
    input  logic [NUM_TIMERS-1:0]       periodic,
    output logic [NUM_TIMERS-1:0]       busy,
    output logic [NUM_TIMERS-1:0]       expire,
    output logic                        tick
);

    localparam int DIV   = fdd_div(CLK_FREQ, TICK_FREQ);
    localparam int IDX_W = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TIMERS - 1);

    // A full sweep must finish before the next tick, otherwise ticks would be lost.
    if (DIV < NUM_TIMERS + 1) begin : g_div_check
        $error("fdd_timer_sched: DIV must be at least NUM_TIMERS+1");
    end
    if (NUM_TIMERS < 1 || NUM_TIMERS > 16) begin : g_num_check
        $error("fdd_timer_sched: NUM_TIMERS must be in 1..16");
    end

    tsched_state_t          state;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       cnt [NUM_TIMERS];
    logic [CNT_W-1:0]       cur_cnt;
    logic [CNT_W-1:0]       dec_cnt;
    logic                   cur_term;
    logic [NUM_TIMERS-1:0]  slot;

    fdd_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .TICK_FREQ (TICK_FREQ)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SWEEP;
                        idx   <= '0;
                    end
                end
                SWEEP: begin
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single shared decrementer: only the timer in the current slot is ever decremented.
    always_comb begin
        cur_cnt  = cnt[idx];
        dec_cnt  = cur_cnt - CNT_W'(1);
        cur_term = (cur_cnt == CNT_W'(1));
        slot     = '0;
        if (state == SWEEP) begin
            slot[idx] = 1'b1;
        end
    end

`ifdef FDD_TSCHED_AUTORELOAD_EN
    logic [CNT_W-1:0] reload [NUM_TIMERS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                reload[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (start[i]) begin
                    reload[i] <= load_val[i*CNT_W +: CNT_W];
                end
            end
        end
    end
`else
    logic unused_periodic;
    assign unused_periodic = ^periodic;
`endif

    // Per timer: start beats cancel beats the sweep slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy   <= '0;
            expire <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                expire[i] <= 1'b0;
                if (start[i]) begin
                    cnt[i]    <= load_val[i*CNT_W +: CNT_W];
                    busy[i]   <= (load_val[i*CNT_W +: CNT_W] != '0);
                    expire[i] <= (load_val[i*CNT_W +: CNT_W] == '0);
                end else if (cancel[i]) begin
                    busy[i] <= 1'b0;
                end else if (slot[i] && busy[i]) begin
                    if (cur_term) begin
                        expire[i] <= 1'b1;
`ifdef FDD_TSCHED_AUTORELOAD_EN
                        if (periodic[i]) begin
                            cnt[i] <= reload[i];
                        end else begin
                            cnt[i]  <= '0;
                            busy[i] <= 1'b0;
                        end
`else
                        cnt[i]  <= '0;
                        busy[i] <= 1'b0;
`endif
                    end else begin
                        cnt[i] <= dec_cnt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fdd_timer_sched.sv
// tb/tb_fdd_timer_sched.sv - table-driven bench for fdd_timer_sched (DIV=21, 4 timers; FDD_TSCHED_AUTORELOAD_EN optional)
module tb_fdd_timer_sched;

    localparam int NT = 4;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NT-1:0]    start;
    logic [NT*CW-1:0] load_val;
    logic [NT-1:0]    cancel;
    logic [NT-1:0]    periodic;
    logic [NT-1:0]    busy;
    logic [NT-1:0]    expire;
    logic             tick;

    always #5 clk = ~clk;

    fdd_timer_sched #(
        .CLK_FREQ   (21477270),
        .TICK_FREQ  (1000000),
        .NUM_TIMERS (NT),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .load_val (load_val),
        .cancel   (cancel),
        .periodic (periodic),
        .busy     (busy),
        .expire   (expire),
        .tick     (tick)
    );

    typedef struct {
        int            seg;
        int            cyc;
        logic [NT-1:0] st;
        logic [NT-1:0] ca;
        logic [NT*CW-1:0] ld;
        bit            chk;
        logic [NT-1:0] bsy;
    } vec_t;

    typedef struct {
        int            seg;
        int            cyc;
        logic [NT-1:0] m;
    } exp_t;

    vec_t vecs[$];
    exp_t exps[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [NT*CW-1:0] lv(input int t, input int v);
        logic [NT*CW-1:0] r;
        r = '0;
        r[t*CW +: CW] = CW'(v);
        return r;
    endfunction

    function automatic vec_t mk(input int seg, input int cyc, input logic [NT-1:0] st,
                                input logic [NT-1:0] ca, input logic [NT*CW-1:0] ld,
                                input bit chk, input logic [NT-1:0] bsy);
        vec_t r;
        r.seg = seg; r.cyc = cyc; r.st = st; r.ca = ca; r.ld = ld; r.chk = chk; r.bsy = bsy;
        return r;
    endfunction

    function automatic exp_t mx(input int seg, input int cyc, input logic [NT-1:0] m);
        exp_t r;
        r.seg = seg; r.cyc = cyc; r.m = m;
        return r;
    endfunction

    task automatic check(input string name, input int seg, input int cyc,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s seg%0d cyc%0d got %0h want %0h", name, seg, cyc, got, want);
        end
    endtask

    task automatic run_seg(input int seg, input int ncyc);
        logic [NT-1:0] want_exp;
        logic          want_tick;
        for (int c = 0; c < ncyc; c++) begin
            want_exp = '0;
            foreach (vecs[k]) begin
                if (vecs[k].seg == seg && vecs[k].cyc == c) begin
                    start    = start | vecs[k].st;
                    cancel   = cancel | vecs[k].ca;
                    load_val = load_val | vecs[k].ld;
                    if (vecs[k].chk) check("busy", seg, c, 32'(busy), 32'(vecs[k].bsy));
                end
            end
            foreach (exps[k]) begin
                if (exps[k].seg == seg && exps[k].cyc == c) want_exp = want_exp | exps[k].m;
            end
            want_tick = (c >= 20) && ((c - 20) % 21 == 0);
            check("expire", seg, c, 32'(expire), 32'(want_exp));
            check("tick", seg, c, 32'(tick), 32'(want_tick));
            @(posedge clk);
            #1;
            start    = '0;
            cancel   = '0;
            load_val = '0;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start = '0; cancel = '0; load_val = '0; periodic = '0;

        // Segment 1: one-shot behaviour, priorities, cancel, zero load.
        vecs.push_back(mk(1,   0, 4'b0000, 4'b0000, '0, 1'b1, 4'b0000));
        vecs.push_back(mk(1,   5, 4'b0001, 4'b0000, lv(0, 3), 1'b0, 4'b0000));
        vecs.push_back(mk(1,   6, 4'b0000, 4'b0000, '0, 1'b1, 4'b0001));
        vecs.push_back(mk(1,  10, 4'b1010, 4'b0000, lv(3, 5) | lv(1, 0), 1'b0, 4'b0000));
        vecs.push_back(mk(1,  11, 4'b0000, 4'b0000, '0, 1'b1, 4'b1001));
        vecs.push_back(mk(1,  15, 4'b0100, 4'b0000, lv(2, 4), 1'b0, 4'b0000));
        vecs.push_back(mk(1,  16, 4'b0000, 4'b0000, '0, 1'b1, 4'b1101));
        vecs.push_back(mk(1,  50, 4'b0000, 4'b0100, '0, 1'b1, 4'b1101));
        vecs.push_back(mk(1,  51, 4'b0000, 4'b0000, '0, 1'b1, 4'b1001));
        vecs.push_back(mk(1,  60, 4'b0010, 4'b0000, lv(1, 3), 1'b0, 4'b0000));
        vecs.push_back(mk(1,  61, 4'b0000, 4'b0000, '0, 1'b1, 4'b1011));
        vecs.push_back(mk(1,  63, 4'b0000, 4'b0000, '0, 1'b1, 4'b1011));
        vecs.push_back(mk(1,  64, 4'b0000, 4'b0000, '0, 1'b1, 4'b1010));
        vecs.push_back(mk(1,  70, 4'b0001, 4'b0001, lv(0, 2), 1'b0, 4'b0000));
        vecs.push_back(mk(1,  71, 4'b0000, 4'b0000, '0, 1'b1, 4'b1011));
        vecs.push_back(mk(1,  85, 4'b0010, 4'b0000, lv(1, 2), 1'b0, 4'b0000));
        vecs.push_back(mk(1,  86, 4'b0000, 4'b0000, '0, 1'b1, 4'b1011));
        vecs.push_back(mk(1, 104, 4'b0100, 4'b0000, lv(2, 1), 1'b0, 4'b0000));
        vecs.push_back(mk(1, 105, 4'b0000, 4'b0000, '0, 1'b1, 4'b1111));
        vecs.push_back(mk(1, 106, 4'b0000, 4'b0000, '0, 1'b1, 4'b1110));
        vecs.push_back(mk(1, 108, 4'b0000, 4'b0000, '0, 1'b1, 4'b1010));
        vecs.push_back(mk(1, 109, 4'b0000, 4'b0000, '0, 1'b1, 4'b0010));
        vecs.push_back(mk(1, 120, 4'b0000, 4'b1000, '0, 1'b0, 4'b0000));
        vecs.push_back(mk(1, 127, 4'b0000, 4'b0000, '0, 1'b1, 4'b0010));
        vecs.push_back(mk(1, 128, 4'b0000, 4'b0000, '0, 1'b1, 4'b0000));
        vecs.push_back(mk(1, 130, 4'b1001, 4'b0000, lv(0, 2) | lv(3, 1), 1'b0, 4'b0000));
        vecs.push_back(mk(1, 131, 4'b0000, 4'b0000, '0, 1'b1, 4'b1001));
        vecs.push_back(mk(1, 147, 4'b0000, 4'b0000, '0, 1'b1, 4'b1001));
        exps.push_back(mx(1,  11, 4'b0010));
        exps.push_back(mx(1,  64, 4'b0001));
        exps.push_back(mx(1, 106, 4'b0001));
        exps.push_back(mx(1, 108, 4'b0100));
        exps.push_back(mx(1, 109, 4'b1000));
        exps.push_back(mx(1, 128, 4'b0010));

        // Segment 2: periodic timer 1 when auto-reload is built, otherwise an idle run.
        vecs.push_back(mk(2,   0, 4'b0000, 4'b0000, '0, 1'b1, 4'b0000));
`ifdef FDD_TSCHED_AUTORELOAD_EN
        vecs.push_back(mk(2,   5, 4'b0010, 4'b0000, lv(1, 2), 1'b0, 4'b0000));
        vecs.push_back(mk(2,   6, 4'b0000, 4'b0000, '0, 1'b1, 4'b0010));
        vecs.push_back(mk(2,  44, 4'b0000, 4'b0000, '0, 1'b1, 4'b0010));
        vecs.push_back(mk(2,  50, 4'b0000, 4'b0000, '0, 1'b1, 4'b0010));
        vecs.push_back(mk(2,  90, 4'b0000, 4'b0000, '0, 1'b1, 4'b0010));
        exps.push_back(mx(2,  44, 4'b0010));
        exps.push_back(mx(2,  86, 4'b0010));
`else
        vecs.push_back(mk(2,  50, 4'b0000, 4'b0000, '0, 1'b1, 4'b0000));
`endif

        // Segment 3: after a mid-sweep reset nothing may be left running.
        vecs.push_back(mk(3,   0, 4'b0000, 4'b0000, '0, 1'b1, 4'b0000));
        vecs.push_back(mk(3,  25, 4'b0000, 4'b0000, '0, 1'b1, 4'b0000));

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 0, 0, 32'(busy), 32'h0);
        check("rst_expire", 0, 0, 32'(expire), 32'h0);
        check("rst_tick", 0, 0, 32'(tick), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        run_seg(1, 148);

        // Cycle 148 is inside the sweep following the tick at 146.
        reset_n = 1'b0;
        #1;
        check("midsweep_rst_busy", 1, 148, 32'(busy), 32'h0);
        check("midsweep_rst_expire", 1, 148, 32'(expire), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
`ifdef FDD_TSCHED_AUTORELOAD_EN
        periodic = 4'b0010;
`endif
        run_seg(2, 106);

        // Cycle 106 is inside the sweep following the tick at 104.
        reset_n = 1'b0;
        #1;
        check("midsweep_rst2_busy", 2, 106, 32'(busy), 32'h0);
        check("midsweep_rst2_expire", 2, 106, 32'(expire), 32'h0);
        periodic = '0;
        @(negedge clk);
        reset_n = 1'b1;
        run_seg(3, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
